mprj_io_cfg_loader: RTL and testbench

Serial configuration transmitter for the user-project GPIO pad array. It holds one configuration word per pad and shifts all words out over two serial chains, one for area 1 and one for area 2, into the per-pad GPIO control blocks. Those blocks drive the pad array's `oeb`, `dm`, `inp_dis` and related inputs. A strobe then latches the shifted data into every pad at once. The block sits in housekeeping, clocked by the Wishbone clock.

---
 rtl/mprj_cfg_pkg.sv | 35 +++
 rtl/mprj_cfg_bitclk.sv | 39 +++
 rtl/mprj_io_cfg_loader.sv | 156 +++++++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_cfg_pkg.sv
// Shared types and constants for the user-pad serial configuration loader:
// FSM state encoding, word width, reset word and configuration-word bit positions.
package mprj_cfg_pkg;

    localparam int MPRJ_IO_PADS   = 38;
    localparam int MPRJ_IO_PADS_1 = 19;

    localparam int CFG_BITS = 13;
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403;

    localparam int MGMT_EN     = 0;
    localparam int OUT_DIS     = 1;
    localparam int HOLDOVER    = 2;
    localparam int INP_DIS     = 3;
    localparam int IB_MODE_SEL = 4;
    localparam int ANALOG_EN   = 5;
    localparam int ANALOG_SEL  = 6;
    localparam int ANALOG_POL  = 7;
    localparam int SLOW        = 8;
    localparam int VTRIP       = 9;
    localparam int DM_LSB      = 10;
    localparam int DM_MSB      = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mprj_cfg_bitclk.sv
// Serial-clock phase generator: a CLK_DIV down-counter toggles the clock phase;
// bit_adv marks the last system cycle of each serial bit period.
module mprj_cfg_bitclk #(
    parameter int CLK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic run,
    input  logic gate,
    output logic bit_adv,
    output logic serial_clock
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          phase;

    // Held at the start of a low phase whenever idle, so each run begins with a full low half.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt <= DIV_LOAD;
            phase   <= 1'b0;
        end else if (!run) begin
            div_cnt <= DIV_LOAD;
            phase   <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign bit_adv      = run && phase && (div_cnt == '0);
    assign serial_clock = phase && gate;

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Per-pad configuration store and dual-chain serial shifter for the user GPIO pads.
// Define MPRJ_CFG_AUTOLOAD_EN to launch one transfer automatically after reset release.
//
// state | meaning
// IDLE  | waiting for start; storage writable
// SHIFT | shifting NB bits out on both chains
// LOAD  | serial_load high for one bit period
// DONE  | one-cycle done pulse, busy already low
module mprj_io_cfg_loader #(
    parameter int TOTAL_PADS = mprj_cfg_pkg::MPRJ_IO_PADS,
    parameter int AREA1PADS  = mprj_cfg_pkg::MPRJ_IO_PADS_1,
    parameter int CFG_BITS   = mprj_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV    = 2,
    parameter logic [CFG_BITS-1:0] CFG_DEFAULT = CFG_BITS'(mprj_cfg_pkg::CFG_DEFAULT)
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          cfg_we,
    input  logic [$clog2(TOTAL_PADS)-1:0] cfg_addr,
    input  logic [CFG_BITS-1:0]           cfg_wdata,
    output logic [CFG_BITS-1:0]           cfg_rdata,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          serial_clock,
    output logic                          serial_load,
    output logic                          serial_data_1,
    output logic                          serial_data_2
);

    import mprj_cfg_pkg::*;

    localparam int AW  = $clog2(TOTAL_PADS);
    localparam int P2  = TOTAL_PADS - AREA1PADS;
    localparam int L   = imax(AREA1PADS, P2);
    localparam int NB  = L * CFG_BITS;
    localparam int BCW = $clog2(NB + 1);
    localparam int WCW = $clog2(L + 1);
    localparam int BPW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    cfg_state_t           state_q, state_d;
    logic [CFG_BITS-1:0]  cfg_mem [TOTAL_PADS];
    logic                 addr_ok;
    logic                 start_eff;
    logic                 bit_adv;
    logic                 run, gate;
    logic [BCW-1:0]       bits_left;
    logic [WCW-1:0]       word_left;
    logic [BPW-1:0]       bit_pos;
    logic [AW-1:0]        pad1, pad2;
    logic                 on1, on2, bit1, bit2;

    assign addr_ok   = int'(cfg_addr) < TOTAL_PADS;
    assign cfg_rdata = addr_ok ? cfg_mem[cfg_addr] : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < TOTAL_PADS; i++) cfg_mem[i] <= CFG_DEFAULT;
        end else if (cfg_we && !busy && addr_ok) begin
            cfg_mem[cfg_addr] <= cfg_wdata;
        end
    end

`ifdef MPRJ_CFG_AUTOLOAD_EN
    logic auto_pend;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) auto_pend <= 1'b1;
        else          auto_pend <= 1'b0;
    end
    assign start_eff = start | auto_pend;
`else
    assign start_eff = start;
`endif

    assign run  = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
    assign gate = (state_q == ST_SHIFT);

    mprj_cfg_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .run          (run),
        .gate         (gate),
        .bit_adv      (bit_adv),
        .serial_clock (serial_clock)
    );

    // word_left counts chain slots L..1; bit_pos walks each word MSB first.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bits_left <= '0;
            word_left <= '0;
            bit_pos   <= '0;
        end else if (state_q == ST_IDLE && start_eff) begin
            bits_left <= BCW'(NB);
            word_left <= WCW'(L);
            bit_pos   <= BPW'(CFG_BITS - 1);
        end else if (state_q == ST_SHIFT && bit_adv) begin
            bits_left <= bits_left - 1'b1;
            if (bit_pos == '0) begin
                bit_pos   <= BPW'(CFG_BITS - 1);
                word_left <= word_left - 1'b1;
            end else begin
                bit_pos <= bit_pos - 1'b1;
            end
        end
    end

    // Slot s = L-word_left: chain 1 carries pad L-1-s, chain 2 pad AREA1PADS+s-(L-P2);
    // slots before a shorter chain's first pad are zero fill.
    always_comb begin
        pad1 = AW'(word_left - 1'b1);
        pad2 = AW'(TOTAL_PADS - int'(word_left));
        on1  = (word_left != '0) && (int'(word_left) <= AREA1PADS);
        on2  = (word_left != '0) && (int'(word_left) <= P2);
        bit1 = 1'b0;
        bit2 = 1'b0;
        if (on1) bit1 = cfg_mem[pad1][bit_pos];
        if (on2) bit2 = cfg_mem[pad2][bit_pos];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        serial_load   = 1'b0;
        serial_data_1 = 1'b0;
        serial_data_2 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_eff) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy          = 1'b1;
                serial_data_1 = bit1;
                serial_data_2 = bit2;
                if (bit_adv && bits_left == BCW'(1)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                serial_load = 1'b1;
                if (bit_adv) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Bench for mprj_io_cfg_loader: two instances (19- and 20-pad area 1) checked every cycle
// against a time-based model of the serial streams, plus literal expectations.
module tb_mprj_io_cfg_loader;

    localparam int TP = 38;
    localparam int CB = 13;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [12:0] cfg_wdata = '0;
    logic        start = 1'b0;

    logic [1:0]  busy_w, done_w, sclk_w, load_w, d1_w, d2_w;
    logic [12:0] rdata_w [2];

    always #5 clk = ~clk;

    mprj_io_cfg_loader #(.TOTAL_PADS(38), .AREA1PADS(19), .CFG_BITS(13), .CLK_DIV(2)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_w[0]), .start(start), .busy(busy_w[0]),
        .done(done_w[0]), .serial_clock(sclk_w[0]), .serial_load(load_w[0]),
        .serial_data_1(d1_w[0]), .serial_data_2(d2_w[0]));

    mprj_io_cfg_loader #(.TOTAL_PADS(38), .AREA1PADS(20), .CFG_BITS(13), .CLK_DIV(2)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(rdata_w[1]), .start(start), .busy(busy_w[1]),
        .done(done_w[1]), .serial_clock(sclk_w[1]), .serial_load(load_w[1]),
        .serial_data_1(d1_w[1]), .serial_data_2(d2_w[1]));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [12:0] mem [2][TP];
    bit          active [2];
    int          t0 [2];
    logic        prev_rst = 1'b1;

    function automatic int area1(input int i);
        return (i == 0) ? 19 : 20;
    endfunction

    function automatic int slots(input int i);
        return (area1(i) > TP - area1(i)) ? area1(i) : TP - area1(i);
    endfunction

    function automatic logic sbit(input int i, input int chain, input int k);
        int p, z, j, w, pad;
        p = (chain == 1) ? area1(i) : TP - area1(i);
        z = (slots(i) - p) * CB;
        if (k < z) return 1'b0;
        j   = k - z;
        w   = j / CB;
        pad = (chain == 1) ? area1(i) - 1 - w : area1(i) + w;
        return mem[i][pad][CB - 1 - (j % CB)];
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d, sh, k;
            logic eb, ed, ec, el, e1, e2, st;
            logic [12:0] er;
            eb = 0; ed = 0; ec = 0; el = 0; e1 = 0; e2 = 0;
            d  = 0;
            sh = slots(i) * CB * 2 * CD;
            if (rst) begin
                for (int p = 0; p < TP; p++) mem[i][p] = 13'h0403;
                active[i] = 0;
            end else if (active[i]) begin
                d = cyc - t0[i];
                if (d >= 1 && d <= sh) begin
                    k  = (d - 1) / (2 * CD);
                    ec = ((d - 1) % (2 * CD)) >= CD;
                    e1 = sbit(i, 1, k);
                    e2 = sbit(i, 2, k);
                    eb = 1;
                end else if (d > sh && d <= sh + 2 * CD) begin
                    eb = 1;
                    el = 1;
                end else if (d == sh + 2 * CD + 1) begin
                    ed = 1;
                end
            end
            er = (int'(cfg_addr) < TP) ? mem[i][cfg_addr] : 13'h0;
            check($sformatf("inst%0d outs{busy,done,sclk,load,d1,d2}", i),
                  32'({busy_w[i], done_w[i], sclk_w[i], load_w[i], d1_w[i], d2_w[i]}),
                  32'({eb, ed, ec, el, e1, e2}));
            check($sformatf("inst%0d cfg_rdata", i), 32'(rdata_w[i]), 32'(er));
            if (!rst) begin
                if (cfg_we && !eb && int'(cfg_addr) < TP) mem[i][cfg_addr] = cfg_wdata;
                st = start;
`ifdef MPRJ_CFG_AUTOLOAD_EN
                if (prev_rst) st = 1'b1;
`endif
                if (st && (!active[i] || d >= sh + 2 * CD + 2)) begin
                    active[i] = 1;
                    t0[i]     = cyc;
                end
            end
        end
        prev_rst = rst;
        cyc++;
    end

    // ---------------- serial bit capture at rising serial_clock ----------------
    bit   cap_en = 0;
    logic qa1[$], qa2[$], qb1[$], qb2[$];

    always @(posedge sclk_w[0]) if (cap_en) begin qa1.push_back(d1_w[0]); qa2.push_back(d2_w[0]); end
    always @(posedge sclk_w[1]) if (cap_en) begin qb1.push_back(d1_w[1]); qb2.push_back(d2_w[1]); end

    task automatic wr(input int a, input logic [12:0] v);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_wdata = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // mode 0: plain transfer; 1: write and restart while busy; 2: reset at bit 100
    task automatic run_xfer(input int mode, output int na, output int nbb,
                            output int nload, output int ndone);
        na = 0; nbb = 0; nload = 0; ndone = 0;
        qa1.delete(); qa2.delete(); qb1.delete(); qb2.delete();
        cap_en = 1;
        cfg_addr = 6'd5;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            start     = (i == 0) || (mode == 1 && i == 300);
            cfg_we    = (mode == 1 && i == 50);
            cfg_wdata = 13'h1234;
            if (mode == 2 && i == 401) begin
                check("busy before mid-transfer reset", 32'(busy_w[0]), 32'd1);
                rst = 1'b1;
                #1;
                check("async reset outs inst0", 32'({busy_w[0], done_w[0], sclk_w[0], load_w[0], d1_w[0], d2_w[0]}), 32'd0);
                check("async reset outs inst1", 32'({busy_w[1], done_w[1], sclk_w[1], load_w[1], d1_w[1], d2_w[1]}), 32'd0);
            end
            if (mode == 2 && i == 404) rst = 1'b0;
            @(negedge clk);
            if (busy_w[0]) na++;
            if (busy_w[1]) nbb++;
            if (load_w[0] && !(mode == 2 && i > 404)) nload++;
            if (done_w[0]) ndone++;
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        cap_en = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; cfg_we = 1'b0;
        end
    endtask

    initial begin
        int na, nbb, nload, ndone, nbusy;
        logic [12:0] defw;
        defw = 13'h0403;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("reset rdata pad0", 32'(rdata_w[0]), 32'h0403);

`ifdef MPRJ_CFG_AUTOLOAD_EN
        @(negedge clk); @(negedge clk);
        check("autoload busy after release", 32'(busy_w[0]), 32'd1);
        idle_cycles(1100);
`else
        nbusy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy_w != 2'b00) nbusy++;
        end
        check("no busy without start", 32'(nbusy), 32'd0);
`endif

        // defaults on both chains
        run_xfer(0, na, nbb, nload, ndone);
        check("busy cycles inst0", 32'(na), 32'd992);
        check("busy cycles inst1", 32'(nbb), 32'd1044);
        check("load cycles", 32'(nload), 32'd4);
        check("done pulses", 32'(ndone), 32'd1);
        check("sclk edges inst0", 32'(qa1.size()), 32'd247);
        check("sclk edges inst1", 32'(qb1.size()), 32'd260);
        for (int k = 0; k < 247 && k < qa1.size(); k++) begin
            check($sformatf("default chain1 bit%0d", k), 32'(qa1[k]), 32'(defw[12 - k % 13]));
            check($sformatf("default chain2 bit%0d", k), 32'(qa2[k]), 32'(defw[12 - k % 13]));
        end
        for (int k = 0; k < 260 && k < qb2.size(); k++) begin
            check($sformatf("b chain2 bit%0d", k), 32'(qb2[k]), (k < 26) ? 32'd0 : 32'(defw[12 - k % 13]));
            check($sformatf("b chain1 bit%0d", k), 32'(qb1[k]), 32'(defw[12 - k % 13]));
        end

        // boundary pads of each chain
        for (int p = 0; p < TP; p++) wr(p, (p == 18) ? 13'h1FFF : (p == 19) ? 13'h0001 : 13'h0000);
        run_xfer(0, na, nbb, nload, ndone);
        check("pattern edges", 32'(qa1.size()), 32'd247);
        for (int k = 0; k < 247 && k < qa1.size(); k++) begin
            check($sformatf("pattern chain1 bit%0d", k), 32'(qa1[k]), 32'(k < 13));
            check($sformatf("pattern chain2 bit%0d", k), 32'(qa2[k]), 32'(k == 12));
        end

        // write and second start while busy
        run_xfer(1, na, nbb, nload, ndone);
        check("busy not extended", 32'(na), 32'd992);
        @(posedge clk); #1 cfg_addr = 6'd5;
        #1 check("pad5 write dropped", 32'(rdata_w[0]), 32'd0);

        // out-of-range write
        wr(45, 13'h1ABC);
        #1 check("out of range rdata", 32'(rdata_w[0]), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 149) == 0);
            cfg_we    = ($urandom_range(0, 2) == 0);
            cfg_addr  = 6'($urandom_range(0, 63));
            cfg_wdata = 13'($urandom);
        end
        idle_cycles(1100);

        // reset in the middle of bit 100
        run_xfer(2, na, nbb, nload, ndone);
        check("no load on aborted transfer", 32'(nload), 32'd0);
        for (int p = 0; p < TP; p++) begin
            @(posedge clk); #1 cfg_addr = 6'(p);
            #1 check($sformatf("post-reset pad%0d", p), 32'(rdata_w[0]), 32'h0403);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
